// File: rtl/yarvi_code_arb_pkg.sv
// Shared types and defaults for the code-memory write-port arbiter.
// VMSB sets the byte-address MSB used across the fetch/execute slice.
package yarvi_code_arb_pkg;

  localparam int VMSB             = 15;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RESTART = 2'd3
  } arb_state_t;

endpackage

// File: rtl/yarvi_code_arb.sv
// Shares the fetch code-write port between EX stores and an image loader,
// quiescing the pipeline before the loader is granted and restarting at its entry point.
module yarvi_code_arb
  import yarvi_code_arb_pkg::*;
#(
  parameter int AMSB         = VMSB,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [AMSB:2]   i_ex_address,
  input  logic [31:0]     i_ex_writedata,
  input  logic [3:0]      i_ex_writemask,
  input  logic            i_ex_restart,
  input  logic [AMSB:0]   i_ex_restart_pc,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [AMSB:2]   i_ld_address,
  input  logic [31:0]     i_ld_writedata,
  input  logic [3:0]      i_ld_writemask,
  input  logic            i_ld_last,
  input  logic [AMSB:0]   i_ld_start_pc,
  output logic [AMSB:2]   o_code_address,
  output logic [31:0]     o_code_writedata,
  output logic [3:0]      o_code_writemask,
  output logic            o_restart,
  output logic [AMSB:0]   o_restart_pc,
  output logic            o_hold,
  output logic [15:0]     o_ld_beats,
  output logic            o_ex_conflict
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  arb_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_drain, w_drain_nxt;
  logic [15:0]   r_beats, w_beats_nxt;
  logic          r_conflict, w_conflict_nxt;
  logic [AMSB:0] r_pc, w_pc_nxt;
  logic          w_quiet;

  assign w_quiet = (i_ex_writemask == 4'd0) && !i_ex_restart;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_drain    <= '0;
      r_beats    <= '0;
      r_conflict <= 1'b0;
      r_pc       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drain    <= w_drain_nxt;
      r_beats    <= w_beats_nxt;
      r_conflict <= w_conflict_nxt;
      r_pc       <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_drain_nxt      = r_drain;
    w_beats_nxt      = r_beats;
    w_conflict_nxt   = r_conflict;
    w_pc_nxt         = r_pc;
    o_code_address   = i_ex_address;
    o_code_writedata = i_ex_writedata;
    o_code_writemask = i_ex_writemask;
    o_restart        = i_ex_restart;
    o_restart_pc     = i_ex_restart_pc;
    o_hold           = 1'b1;
    o_ld_ready       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        o_hold = 1'b0;
        if (i_ld_valid) begin
          w_state_nxt = ST_QUIESCE;
          w_drain_nxt = '0;
          w_beats_nxt = '0;
        end
      end
      ST_QUIESCE: begin
        // Any EX write or restart means the pipeline is not yet drained.
        if (w_quiet) begin
          w_drain_nxt = r_drain + 1'b1;
          if (r_drain == CW'(DRAIN_CYCLES - 1)) w_state_nxt = ST_GRANT;
        end else begin
          w_drain_nxt = '0;
        end
      end
      ST_GRANT: begin
        o_ld_ready       = 1'b1;
        o_restart        = 1'b0;
        o_code_address   = i_ld_address;
        o_code_writedata = i_ld_writedata;
        o_code_writemask = i_ld_valid ? i_ld_writemask : 4'd0;
        if (i_ex_writemask != 4'd0) w_conflict_nxt = 1'b1;
        if (i_ld_valid) begin
          if (r_beats != 16'hFFFF) w_beats_nxt = r_beats + 16'd1;
          if (i_ld_last) begin
            w_pc_nxt    = i_ld_start_pc;
            w_state_nxt = ST_RESTART;
          end
        end
      end
      ST_RESTART: begin
        o_restart        = 1'b1;
        o_restart_pc     = r_pc;
        o_code_writemask = 4'd0;
        w_state_nxt      = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_ld_beats    = r_beats;
  assign o_ex_conflict = r_conflict;

endmodule

// File: tb/tb_yarvi_code_arb.sv
// Randomized bench for yarvi_code_arb: a loader/EX driver feeds a behavioural model that
// queues expected code writes, restarts and status; a negedge monitor compares the DUT.
module tb_yarvi_code_arb;
  import yarvi_code_arb_pkg::*;

  localparam int AMSB  = VMSB;
  localparam int AW    = AMSB - 1;
  localparam int PW    = AMSB + 1;
  localparam int DRAIN = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AMSB:2]   ex_address = '0;
  logic [31:0]     ex_writedata = '0;
  logic [3:0]      ex_writemask = '0;
  logic            ex_restart = 1'b0;
  logic [AMSB:0]   ex_restart_pc = '0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [AMSB:2]   ld_address = '0;
  logic [31:0]     ld_writedata = '0;
  logic [3:0]      ld_writemask = '0;
  logic            ld_last = 1'b0;
  logic [AMSB:0]   ld_start_pc = '0;
  logic [AMSB:2]   code_address;
  logic [31:0]     code_writedata;
  logic [3:0]      code_writemask;
  logic            restart;
  logic [AMSB:0]   restart_pc;
  logic            hold;
  logic [15:0]     ld_beats;
  logic            ex_conflict;

  yarvi_code_arb #(.AMSB(AMSB), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ex_address(ex_address), .i_ex_writedata(ex_writedata),
    .i_ex_writemask(ex_writemask), .i_ex_restart(ex_restart),
    .i_ex_restart_pc(ex_restart_pc),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_address(ld_address), .i_ld_writedata(ld_writedata),
    .i_ld_writemask(ld_writemask), .i_ld_last(ld_last),
    .i_ld_start_pc(ld_start_pc),
    .o_code_address(code_address), .o_code_writedata(code_writedata),
    .o_code_writemask(code_writemask),
    .o_restart(restart), .o_restart_pc(restart_pc),
    .o_hold(hold), .o_ld_beats(ld_beats), .o_ex_conflict(ex_conflict)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [AMSB:2] a; logic [31:0] d; logic [3:0] m; } wr_t;
  typedef struct { int cyc; logic [AMSB:0] pc; } rs_t;
  typedef struct { logic hold; logic rdy; logic [15:0] beats; logic conf; } st_t;

  wr_t wq[$];
  rs_t rq[$];
  st_t sq[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;

  // Reference model: where the load transaction stands, described by flags and a quiet-run length.
  bit            m_pending, m_granted, m_restart_due, m_conflict;
  int            m_run, m_beats;
  logic [AMSB:0] m_pc;

  // Loader agent.
  bit            la_active, la_gaps;
  int            la_len, la_idx;
  logic [AMSB:2] la_base;
  logic [31:0]   la_dbase;
  logic [AMSB:0] la_pc;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void fail(string name, logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s cycle %0d: got %0h, required no such event", name, cyc, act);
  endfunction

  function automatic void model_reset();
    m_pending = 0; m_granted = 0; m_restart_due = 0; m_conflict = 0;
    m_run = 0; m_beats = 0; m_pc = '0;
  endfunction

  task automatic start_load(int len, int base, logic [31:0] dbase, int pc, bit gaps);
    la_active = 1; la_len = len; la_idx = 0; la_gaps = gaps;
    la_base = AW'(base); la_dbase = dbase; la_pc = PW'(pc);
  endtask

  task automatic step(bit exw, bit exr, bit rst_low);
    st_t s;
    bit  acc;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_low) la_active = 0;
    ex_address    = AW'($urandom);
    ex_writedata  = $urandom;
    ex_writemask  = exw ? 4'($urandom_range(1, 15)) : 4'd0;
    ex_restart    = exr;
    ex_restart_pc = PW'($urandom);
    ld_valid      = la_active && (!la_gaps || $urandom_range(0, 3) != 0);
    ld_address    = la_base + AW'(la_idx);
    ld_writedata  = la_dbase + 32'(la_idx);
    ld_writemask  = la_gaps ? 4'(la_idx % 15 + 1) : 4'hF;
    ld_last       = la_active && (la_idx == la_len - 1);
    ld_start_pc   = ld_last ? la_pc : PW'($urandom);
    rst_n         = !rst_low;
    if (rst_low) model_reset();

    s.hold  = m_pending || m_granted || m_restart_due;
    s.rdy   = m_granted;
    s.beats = 16'(m_beats);
    s.conf  = m_conflict;
    sq.push_back(s);
    acc = 0;
    if (m_restart_due) begin
      rq.push_back('{cyc, m_pc});
    end else if (m_granted) begin
      if (ld_valid) begin
        acc = 1;
        wq.push_back('{cyc, ld_address, ld_writedata, ld_writemask});
      end
    end else begin
      if (ex_writemask != 0) wq.push_back('{cyc, ex_address, ex_writedata, ex_writemask});
      if (ex_restart) rq.push_back('{cyc, ex_restart_pc});
    end

    if (!rst_low) begin
      if (m_restart_due) begin
        m_restart_due = 0;
      end else if (m_granted) begin
        if (ex_writemask != 0) m_conflict = 1;
        if (acc) begin
          if (m_beats < 65535) m_beats++;
          if (ld_last) begin
            m_pc = ld_start_pc; m_granted = 0; m_restart_due = 1;
          end
        end
      end else if (m_pending) begin
        m_run = (ex_writemask == 0 && !ex_restart) ? m_run + 1 : 0;
        if (m_run == DRAIN) begin
          m_pending = 0; m_granted = 1;
        end
      end else if (ld_valid) begin
        m_pending = 1; m_run = 0; m_beats = 0;
      end
    end

    if (acc) begin
      if (ld_last) la_active = 0;
      else la_idx++;
    end

    if (rst_low) begin
      #1;
      check("rst_hold", 64'(hold), 64'(0));
      check("rst_ld_ready", 64'(ld_ready), 64'(0));
      check("rst_ld_beats", 64'(ld_beats), 64'(0));
      check("rst_ex_conflict", 64'(ex_conflict), 64'(0));
      check("rst_restart", 64'(restart), 64'(ex_restart));
    end
  endtask

  task automatic quiet(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  always @(negedge clk) begin
    st_t e;
    wr_t w;
    rs_t r;
    if (sq.size() == 0) begin
      fail("status_unexpected", 64'(hold));
    end else begin
      e = sq.pop_front();
      check("hold", 64'(hold), 64'(e.hold));
      check("ld_ready", 64'(ld_ready), 64'(e.rdy));
      check("ld_beats", 64'(ld_beats), 64'(e.beats));
      check("ex_conflict", 64'(ex_conflict), 64'(e.conf));
    end
    if (code_writemask != 0) begin
      if (wq.size() == 0 || wq[0].cyc != cyc) begin
        fail("write_unexpected", 64'(code_writemask));
      end else begin
        w = wq.pop_front();
        check("code_address", 64'(code_address), 64'(w.a));
        check("code_writedata", 64'(code_writedata), 64'(w.d));
        check("code_writemask", 64'(code_writemask), 64'(w.m));
      end
    end else if (wq.size() != 0 && wq[0].cyc == cyc) begin
      w = wq.pop_front();
      check("write_missing_mask", 64'(code_writemask), 64'(w.m));
    end
    if (restart) begin
      if (rq.size() == 0 || rq[0].cyc != cyc) begin
        fail("restart_unexpected", 64'(restart_pc));
      end else begin
        r = rq.pop_front();
        check("restart_pc", 64'(restart_pc), 64'(r.pc));
      end
    end else if (rq.size() != 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      check("restart_missing", 64'(restart), 64'(1));
    end
  end

  initial begin
    int guard;
    model_reset();
    la_active = 0;
    step(0, 0, 1);
    step(0, 0, 1);
    // EX stores and restarts pass straight through while idle.
    for (int i = 0; i < 6; i++) step(1, i == 3, 0);

    // Clean 4-beat image: words 0..3, data A0..A3, entry 0x200.
    start_load(4, 0, 32'hA0, 32'h200, 0);
    quiet(12);

    // EX write on the second drain cycle restarts the drain count.
    start_load(3, 16, 32'h5000, 32'h80, 0);
    step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
    quiet(12);

    // EX write while the loader owns the port is dropped and latched as a conflict.
    start_load(4, 32, 32'h7700, 32'h140, 0);
    quiet(4);
    step(1, 1, 0);
    quiet(10);

    // Reset lands on beat 2: nothing written, no loader restart, fresh request afterwards.
    start_load(5, 48, 32'hC000, 32'h300, 0);
    quiet(6);
    step(0, 0, 1);
    step(0, 0, 0);
    start_load(2, 64, 32'hD000, 32'h3C0, 0);
    quiet(12);

    for (int i = 0; i < 4000; i++) begin
      if (!la_active && $urandom_range(0, 19) == 0)
        start_load($urandom_range(1, 12), $urandom, $urandom, $urandom, 1);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
    end

    guard = 0;
    while ((la_active || m_pending || m_granted || m_restart_due) && guard < 300) begin
      step(0, 0, 0);
      guard++;
    end
    check("drain_budget", 64'(la_active || m_pending || m_granted || m_restart_due), 64'(0));
    quiet(2);
    @(negedge clk);
    #1;
    check("writes_left", 64'(wq.size()), 64'(0));
    check("restarts_left", 64'(rq.size()), 64'(0));
    check("status_left", 64'(sq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
